morse_encoder: RTL and testbench
================================

MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 25_000_000, meaning clk cycles per Morse time unit (minimum 2).
REQ-002 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port en  input  1  global enable; 0 pauses all state and counters.
REQ-005 The block SHALL have port char_valid  input  1  producer offers char_code.
REQ-006 The block SHALL have port char_code  input  6  0-25 = A-Z, 26-35 = digits 0-9, 63 = word space.
REQ-007 The block SHALL have port char_ready  output  1  block can accept a character.
REQ-008 The block SHALL have port key_out  output  1  Morse key line, 1 = tone/LED on.
REQ-009 The block SHALL have port busy  output  1  character or space being sent.
REQ-010 The block SHALL have port err  output  1  one-cycle pulse on rejected code.

Function
REQ-011 The block SHALL use the states IDLE, MARK, GAP, CHAR_GAP and WORD_GAP.
REQ-012 char_ready SHALL be 1 only in IDLE with en=1; the transfer occurs on a clock edge where char_valid=1 and char_ready=1.
REQ-013 A ROM SHALL map each code to a length (1-5) and an element pattern, MSB sent first, 1 = dash, 0 = dot; A-Z and 0-9 follow ITU-R M.1677.
REQ-014 The cycle after an accepted letter or digit, the state SHALL be MARK with key_out=1 and busy=1.
REQ-015 MARK SHALL last 1 unit for a dot and 3 units for a dash; key_out SHALL be 1 throughout MARK.
REQ-016 After a MARK that is not the last element, the state SHALL be GAP (key_out=0) for 1 unit, then MARK for the next element.
REQ-017 After the last element, the state SHALL be CHAR_GAP (key_out=0) for 3 units, then IDLE.
REQ-018 An accepted code 63 SHALL enter WORD_GAP for 4 units with key_out=0 and busy=1, then IDLE; this gives a 7-unit word space after the preceding character gap.
REQ-019 Unit timing SHALL come from a down-counter reloaded with UNIT_CYCLES-1; one unit equals exactly UNIT_CYCLES enabled clk cycles.
REQ-020 A rejected code SHALL pulse err for one cycle on the accepting edge, leave the state in IDLE, and keep key_out=0.
REQ-021 Codes 36-62 SHALL always be rejected.
REQ-022 While en=0, state, counters and key_out SHALL hold, char_ready SHALL be 0 and err SHALL be 0; timing SHALL resume exactly where it stopped.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 char_code SHALL be sampled only on the accepting edge; later changes on char_code SHALL have no effect on the character in progress.
REQ-025 Back-to-back valid characters SHALL be accepted on the first IDLE cycle, with no extra idle cycle added.

Reset
REQ-026 rst SHALL force the state to IDLE, all counters to 0, key_out=0, busy=0 and err=0 immediately, regardless of clk or en.
REQ-027 A reset asserted in the middle of a character SHALL discard that character; no element SHALL be sent after rst deasserts.
REQ-028 char_ready SHALL be 1 on the first rising edge after rst deasserts when en=1.

Configuration
REQ-029 The macro MORSE_DIGITS_EN SHALL control digit support.
REQ-030 With MORSE_DIGITS_EN defined, codes 26-35 SHALL be encoded as digits 0-9.
REQ-031 Without MORSE_DIGITS_EN, codes 26-35 SHALL be rejected per REQ-020, and their ROM entries SHALL not be synthesized.

Verification (UNIT_CYCLES=4)
REQ-032 Send 'E' (code 4) accepted at edge k -> key_out=1 for edges k+1..k+4, then 0 for 12 cycles; char_ready=1 again at k+17.
REQ-033 Send 'A' (code 0) -> key_out pattern high 4, low 4, high 12, low 12; busy=1 for 32 cycles.
REQ-034 Send 'T' then code 63 back-to-back -> high 12, low 12, low 16; the second character is accepted on the first IDLE cycle.
REQ-035 Send code 40, and code 26 with MORSE_DIGITS_EN undefined -> one-cycle err each, key_out stays 0 and char_ready stays 1; with the macro defined, code 26 -> five 12-cycle dashes.
REQ-036 Drive en=0 for 10 cycles during the dash of 'A' -> the dash still totals 12 enabled cycles; rst asserted mid-dash -> key_out=0 at once and IDLE after release.

Source files
------------

// File: rtl/morse_encoder.sv
// morse_encoder: ITU Morse keyer with unit-timed marks and gaps.
// Define MORSE_DIGITS_EN to add digits 0-9 (codes 26-35); otherwise they are rejected.
module morse_encoder #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);
    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MARK, GAP, CHAR_GAP, WORD_GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    units_q, units_d;
    logic [4:0]    pat_q, pat_d;
    logic [2:0]    left_q, left_d;
    logic          key_q, key_d;
    logic [7:0]    rom_w;
    logic          accept, is_space;

    // {length, pattern left-aligned}; length 0 marks an unsupported code
    function automatic logic [7:0] rom(input logic [5:0] c);
        case (c)
            6'd0:  rom = {3'd2, 5'b01000};
            6'd1:  rom = {3'd4, 5'b10000};
            6'd2:  rom = {3'd4, 5'b10100};
            6'd3:  rom = {3'd3, 5'b10000};
            6'd4:  rom = {3'd1, 5'b00000};
            6'd5:  rom = {3'd4, 5'b00100};
            6'd6:  rom = {3'd3, 5'b11000};
            6'd7:  rom = {3'd4, 5'b00000};
            6'd8:  rom = {3'd2, 5'b00000};
            6'd9:  rom = {3'd4, 5'b01110};
            6'd10: rom = {3'd3, 5'b10100};
            6'd11: rom = {3'd4, 5'b01000};
            6'd12: rom = {3'd2, 5'b11000};
            6'd13: rom = {3'd2, 5'b10000};
            6'd14: rom = {3'd3, 5'b11100};
            6'd15: rom = {3'd4, 5'b01100};
            6'd16: rom = {3'd4, 5'b11010};
            6'd17: rom = {3'd3, 5'b01000};
            6'd18: rom = {3'd3, 5'b00000};
            6'd19: rom = {3'd1, 5'b10000};
            6'd20: rom = {3'd3, 5'b00100};
            6'd21: rom = {3'd4, 5'b00010};
            6'd22: rom = {3'd3, 5'b01100};
            6'd23: rom = {3'd4, 5'b10010};
            6'd24: rom = {3'd4, 5'b10110};
            6'd25: rom = {3'd4, 5'b11000};
`ifdef MORSE_DIGITS_EN
            6'd26: rom = {3'd5, 5'b11111};
            6'd27: rom = {3'd5, 5'b01111};
            6'd28: rom = {3'd5, 5'b00111};
            6'd29: rom = {3'd5, 5'b00011};
            6'd30: rom = {3'd5, 5'b00001};
            6'd31: rom = {3'd5, 5'b00000};
            6'd32: rom = {3'd5, 5'b10000};
            6'd33: rom = {3'd5, 5'b11000};
            6'd34: rom = {3'd5, 5'b11100};
            6'd35: rom = {3'd5, 5'b11110};
`endif
            default: rom = 8'd0;
        endcase
    endfunction

    assign rom_w      = rom(char_code);
    assign is_space   = char_code == 6'd63;
    assign accept     = en && state_q == IDLE && char_valid;
    assign err        = accept && !is_space && rom_w[7:5] == 3'd0;
    assign char_ready = en && state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign key_out    = key_q;

    // A phase lasts (units_q + 1) units of UNIT_CYCLES enabled cycles each
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        units_d = units_q;
        pat_d   = pat_q;
        left_d  = left_q;
        key_d   = key_q;
        if (en) begin
            if (state_q == IDLE) begin
                if (accept && is_space) begin
                    state_d = WORD_GAP;
                    cnt_d   = RELOAD;
                    units_d = 2'd3;
                end else if (accept && rom_w[7:5] != 3'd0) begin
                    state_d = MARK;
                    cnt_d   = RELOAD;
                    units_d = rom_w[4] ? 2'd2 : 2'd0;
                    pat_d   = rom_w[4:0];
                    left_d  = rom_w[7:5] - 3'd1;
                    key_d   = 1'b1;
                end
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (units_q != 2'd0) begin
                units_d = units_q - 2'd1;
                cnt_d   = RELOAD;
            end else begin
                cnt_d = RELOAD;
                case (state_q)
                    MARK: begin
                        key_d = 1'b0;
                        pat_d = pat_q << 1;
                        if (left_q != 3'd0) begin
                            state_d = GAP;
                            left_d  = left_q - 3'd1;
                        end else begin
                            state_d = CHAR_GAP;
                            units_d = 2'd2;
                        end
                    end
                    GAP: begin
                        state_d = MARK;
                        key_d   = 1'b1;
                        units_d = pat_q[4] ? 2'd2 : 2'd0;
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            units_q <= 2'd0;
            pat_q   <= 5'd0;
            left_q  <= 3'd0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            units_q <= units_d;
            pat_q   <= pat_d;
            left_q  <= left_d;
            key_q   <= key_d;
        end
    end
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: scoreboard bench for morse_encoder at UNIT_CYCLES=4.
module tb_morse_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       char_valid = 1'b0;
    logic [5:0] char_code = 6'd0;
    logic       char_ready, key_out, busy, err;

    typedef struct {logic key; logic busy; logic ready;} exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .char_valid(char_valid), .char_code(char_code),
        .char_ready(char_ready), .key_out(key_out), .busy(busy), .err(err)
    );

    function automatic string morse(input logic [5:0] c);
        case (c)
            6'd0: return ".-";     6'd1: return "-...";   6'd2: return "-.-.";
            6'd3: return "-..";    6'd4: return ".";      6'd5: return "..-.";
            6'd6: return "--.";    6'd7: return "....";   6'd8: return "..";
            6'd9: return ".---";   6'd10: return "-.-";   6'd11: return ".-..";
            6'd12: return "--";    6'd13: return "-.";    6'd14: return "---";
            6'd15: return ".--.";  6'd16: return "--.-";  6'd17: return ".-.";
            6'd18: return "...";   6'd19: return "-";     6'd20: return "..-";
            6'd21: return "...-";  6'd22: return ".--";   6'd23: return "-..-";
            6'd24: return "-.--";  6'd25: return "--..";
            6'd26: return "-----"; 6'd27: return ".----"; 6'd28: return "..---";
            6'd29: return "...--"; 6'd30: return "....-"; 6'd31: return ".....";
            6'd32: return "-...."; 6'd33: return "--..."; 6'd34: return "---..";
            6'd35: return "----.";
            default: return "";
        endcase
    endfunction

    task automatic put(input logic k, input logic b, input logic r, input int n);
        exp_t e;
        e.key = k; e.busy = b; e.ready = r;
        repeat (n) sb.push_back(e);
    endtask

    // Expected per-cycle key/busy/ready after the accepting edge
    task automatic push_code(input logic [5:0] c);
        string s;
        if (c == 6'd63) put(1'b0, 1'b1, 1'b0, 16);
        else begin
            s = morse(c);
            for (int j = 0; j < s.len(); j++) begin
                put(1'b1, 1'b1, 1'b0, (s.getc(j) == "-") ? 12 : 4);
                if (j < s.len() - 1) put(1'b0, 1'b1, 1'b0, 4);
            end
            put(1'b0, 1'b1, 1'b0, 12);
        end
    endtask

    task automatic drain(input string tag, input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if ({key_out, busy, char_ready, err} !== {e.key, e.busy, e.ready, 1'b0}) begin
                miscompares++;
                $display("FAIL %s t=%0t key/busy/ready/err got %b%b%b%b want %b%b%b0", tag, $time,
                         key_out, busy, char_ready, err, e.key, e.busy, e.ready);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        vectors++;
        if ({key_out, busy, char_ready, err} !== 4'b0010) begin
            miscompares++;
            $display("FAIL %s idle t=%0t key/busy/ready/err got %b%b%b%b want 0010", tag, $time,
                     key_out, busy, char_ready, err);
        end
    endtask

    // Sends one or two characters back-to-back, checking every cycle
    task automatic send_seq(input string tag, input logic [5:0] c0, input logic [5:0] c1, input int n);
        @(negedge clk);
        char_code = c0;
        char_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1 check_idle(tag);
            @(posedge clk);
            #1;
            if (i + 1 < n) char_code = c1;
            else begin
                char_valid = 1'b0;
                char_code = 6'($urandom_range(0, 35));
            end
            push_code(i == 0 ? c0 : c1);
            drain(tag, sb.size());
            @(negedge clk);
        end
        #1 check_idle(tag);
    endtask

    task automatic reject_one(input string tag, input logic [5:0] c);
        @(negedge clk);
        char_code = c;
        char_valid = 1'b1;
        #1 vectors++;
        if (err !== 1'b1 || char_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s err/ready got %b%b want 11", tag, err, char_ready);
        end
        @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle(tag);
        end
    endtask

    task automatic test_reset;
        #1 vectors++;
        if ({key_out, busy, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset key/busy/err got %b%b%b want 000", key_out, busy, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic test_letters;
        send_seq("E", 6'd4, 6'd0, 1);
        send_seq("A", 6'd0, 6'd0, 1);
        send_seq("Q", 6'd16, 6'd0, 1);
        send_seq("Z", 6'd25, 6'd0, 1);
        send_seq("H", 6'd7, 6'd0, 1);
    endtask

    task automatic test_back_to_back;
        send_seq("T_space", 6'd19, 6'd63, 2);
        send_seq("E_T", 6'd4, 6'd19, 2);
    endtask

    task automatic test_reject;
        reject_one("code40", 6'd40);
        reject_one("code36", 6'd36);
        reject_one("code62", 6'd62);
`ifdef MORSE_DIGITS_EN
        send_seq("digit0", 6'd26, 6'd0, 1);
        send_seq("digit9", 6'd35, 6'd0, 1);
`else
        reject_one("code26", 6'd26);
        reject_one("code35", 6'd35);
`endif
    endtask

    task automatic test_enable;
        exp_t h;
        h.key = 1'b1; h.busy = 1'b1; h.ready = 1'b0;
        @(negedge clk);
        char_code = 6'd0;
        char_valid = 1'b1;
        #1 check_idle("en_A");
        @(posedge clk);
        #1 char_valid = 1'b0;
        push_code(6'd0);
        drain("en_A", 13);
        en = 1'b0;
        repeat (10) sb.push_front(h);
        drain("en_hold", 10);
        en = 1'b1;
        drain("en_A", sb.size());
        @(negedge clk);
        en = 1'b0;
        char_valid = 1'b1;
        char_code = 6'd40;
        #1 vectors++;
        if (char_ready !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL en_idle ready/err got %b%b want 00", char_ready, err);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({key_out, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL en_idle key/busy got %b%b want 00", key_out, busy);
        end
        char_valid = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        char_code = 6'd19;
        char_valid = 1'b1;
        @(posedge clk);
        #1 char_valid = 1'b0;
        push_code(6'd19);
        drain("rst_T", 6);
        #1 rst = 1'b1;
        #1 vectors++;
        if ({key_out, busy, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_mid key/busy/err got %b%b%b want 000", key_out, busy, err);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check_idle("after_rst");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_letters();
        test_back_to_back();
        test_reject();
        test_enable();
        test_reset_mid();
        send_seq("S_after_rst", 6'd18, 6'd0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
